// File: rtl/cell_render_pkg.sv
// Shared encodings for the cell render engine: command codes, FSM states,
// scanner walk modes and default colours.
package cell_render_pkg;

   localparam logic [1:0] CMD_OUTLINE   = 2'd0;
   localparam logic [1:0] CMD_UNOUTLINE = 2'd1;
   localparam logic [1:0] CMD_FILL      = 2'd2;
   localparam logic [1:0] CMD_CLEAR     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_FIN
   } state_t;

   // Which pixels of each cell the scanner visits.
   typedef enum logic [1:0] {
      SCAN_FULL,
      SCAN_BORDER,
      SCAN_INTERIOR
   } scan_mode_t;

   localparam logic [8:0] DEF_GRID_COLOUR   = 9'h000;
   localparam logic [8:0] DEF_BG_COLOUR     = 9'h1FF;
   localparam logic [8:0] DEF_HILITE_COLOUR = 9'b111111000;

endpackage

// File: rtl/cell_render_engine_rect_scanner.sv
// Raster walker over a cell-aligned rectangle, x fastest. Positions the
// selected walk mode never emits are stepped over without spending a cycle.
module rect_scanner
   import cell_render_pkg::*;
#(
   parameter int PX_W     = 9,
   parameter int PY_W     = 8,
   parameter int CELL_DIM = 5,
   localparam int PH_W    = $clog2(CELL_DIM)
) (
   input  logic             iClk,
   input  logic             iResetn,
   input  logic             load,
   input  logic             stall,
   input  scan_mode_t       mode,
   input  logic [PX_W-1:0]  org_x,
   input  logic [PY_W-1:0]  org_y,
   input  logic [PX_W-1:0]  last_x,
   input  logic [PY_W-1:0]  last_y,
   output logic [PX_W-1:0]  x,
   output logic [PY_W-1:0]  y,
   output logic [PH_W-1:0]  phase_x,
   output logic [PH_W-1:0]  phase_y,
   output logic             last
);

   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CELL_DIM - 1);
   localparam logic [PH_W-1:0] PH_INNER = PH_W'(CELL_DIM - 2);

   scan_mode_t       mode_q;
   logic [PX_W-1:0]  org_x_q;
   logic [PX_W-1:0]  last_x_q;
   logic [PY_W-1:0]  last_y_q;

   logic             interior;
   logic             row_border;
   logic             row_end;
   logic             col_end;
   logic [PX_W-1:0]  x_start;
   logic [PH_W-1:0]  ph_start;
   logic [PX_W-1:0]  x_step;
   logic [PH_W-1:0]  ph_x_step;
   logic [PY_W-1:0]  y_step;
   logic [PH_W-1:0]  ph_y_step;

   always_comb begin
      interior   = (mode_q == SCAN_INTERIOR);
      row_border = (phase_y == '0) || (phase_y == PH_LAST);
      x_start    = org_x_q + PX_W'(interior);
      ph_start   = PH_W'(interior);
      // Interior walks stop one pixel short of the closing gridline.
      row_end    = interior ? (x == last_x_q - PX_W'(1)) : (x == last_x_q);
      col_end    = interior ? (y == last_y_q - PY_W'(1)) : (y == last_y_q);
      last       = row_end && col_end;

      x_step    = x + PX_W'(1);
      ph_x_step = (phase_x == PH_LAST) ? '0 : phase_x + PH_W'(1);
      y_step    = y + PY_W'(1);
      ph_y_step = (phase_y == PH_LAST) ? '0 : phase_y + PH_W'(1);

      case (mode_q)
         SCAN_BORDER: begin
            if (!row_border && (phase_x == '0)) begin
               x_step    = x + PX_W'(CELL_DIM - 1);
               ph_x_step = PH_LAST;
            end
         end
         SCAN_INTERIOR: begin
            if (phase_x == PH_INNER) begin
               x_step    = x + PX_W'(3);
               ph_x_step = PH_W'(1);
            end
            if (phase_y == PH_INNER) begin
               y_step    = y + PY_W'(3);
               ph_y_step = PH_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         mode_q   <= SCAN_FULL;
         org_x_q  <= '0;
         last_x_q <= '0;
         last_y_q <= '0;
         x        <= '0;
         y        <= '0;
         phase_x  <= '0;
         phase_y  <= '0;
      end else if (load) begin
         mode_q   <= mode;
         org_x_q  <= org_x;
         last_x_q <= last_x;
         last_y_q <= last_y;
         x        <= org_x + PX_W'(mode == SCAN_INTERIOR);
         y        <= org_y + PY_W'(mode == SCAN_INTERIOR);
         phase_x  <= PH_W'(mode == SCAN_INTERIOR);
         phase_y  <= PH_W'(mode == SCAN_INTERIOR);
      end else if (!stall) begin
         if (row_end) begin
            x       <= x_start;
            phase_x <= ph_start;
            y       <= y_step;
            phase_y <= ph_y_step;
         end else begin
            x       <= x_step;
            phase_x <= ph_x_step;
         end
      end
   end

endmodule

// File: rtl/cell_render_engine.sv
// Cell-level drawing commands in, raster pixel stream with valid/ready out.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a command; latches it on accept
// ST_SETUP | derive rectangle, walk mode and colour; load the scanner
// ST_RUN   | present one pixel per cycle, holding while the sink stalls
// ST_FIN   | single-cycle done pulse, then back to idle
module cell_render_engine
   import cell_render_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int CELL_DIM      = 5,
   parameter int COLOUR_W      = 9,
   parameter int MAX_BRUSH     = 4,
   parameter logic [COLOUR_W-1:0] GRID_COLOUR   = '0,
   parameter logic [COLOUR_W-1:0] BG_COLOUR     = '1,
   parameter logic [COLOUR_W-1:0] HILITE_COLOUR = COLOUR_W'(DEF_HILITE_COLOUR),
   localparam int GRID_W = SCREEN_WIDTH / CELL_DIM,
   localparam int GRID_H = SCREEN_HEIGHT / CELL_DIM,
   localparam int CX_W   = $clog2(GRID_W),
   localparam int CY_W   = $clog2(GRID_H),
   localparam int PX_W   = $clog2(SCREEN_WIDTH),
   localparam int PY_W   = $clog2(SCREEN_HEIGHT),
   localparam int A_W    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
   localparam int B_W    = (MAX_BRUSH > 1) ? $clog2(MAX_BRUSH) : 1
) (
   input  logic                iClk,
   input  logic                iResetn,
   input  logic                iCmdValid,
   output logic                oCmdReady,
   input  logic [1:0]          iCmd,
   input  logic [CX_W-1:0]     iX_cell,
   input  logic [CY_W-1:0]     iY_cell,
   input  logic [COLOUR_W-1:0] iColour,
   input  logic [B_W-1:0]      iBrush,
   output logic [PX_W-1:0]     oX_pixel,
   output logic [PY_W-1:0]     oY_pixel,
   output logic [COLOUR_W-1:0] oColour,
   output logic [A_W-1:0]      oAddress,
   output logic                oPlot,
   output logic                oWren,
   input  logic                iPixReady,
   output logic                oBusy,
   output logic                oDone
);

   localparam int PH_W = $clog2(CELL_DIM);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CELL_DIM - 1);

   state_t                state;
   logic [1:0]            cmd_q;
   logic [CX_W-1:0]       cx_q;
   logic [CY_W-1:0]       cy_q;
   logic [COLOUR_W-1:0]   colour_q;
   logic [B_W-1:0]        brush_q;
   logic [COLOUR_W-1:0]   pix_colour_q;
   logic                  clear_q;

   int                    cx_i;
   int                    cy_i;
   int                    ex_i;
   int                    ey_i;
   logic                  reject;
   scan_mode_t            setup_mode;
   logic [PX_W-1:0]       setup_org_x;
   logic [PY_W-1:0]       setup_org_y;
   logic [PX_W-1:0]       setup_last_x;
   logic [PY_W-1:0]       setup_last_y;
   logic [COLOUR_W-1:0]   setup_colour;
   logic                  setup_wren;

   logic                  scan_load;
   logic                  scan_stall;
   logic                  scan_last;
   logic [PH_W-1:0]       phase_x;
   logic [PH_W-1:0]       phase_y;
   logic                  on_grid;

   always_comb begin
      cx_i = 32'(cx_q);
      cy_i = 32'(cy_q);
      ex_i = cx_i + 32'(brush_q);
      ey_i = cy_i + 32'(brush_q);
      if (ex_i > GRID_W - 1) ex_i = GRID_W - 1;
      if (ey_i > GRID_H - 1) ey_i = GRID_H - 1;

      reject       = ((cx_i >= GRID_W) || (cy_i >= GRID_H)) && (cmd_q != CMD_CLEAR);
      setup_mode   = SCAN_BORDER;
      setup_org_x  = PX_W'(cx_i * CELL_DIM);
      setup_org_y  = PY_W'(cy_i * CELL_DIM);
      setup_last_x = PX_W'(cx_i * CELL_DIM + CELL_DIM - 1);
      setup_last_y = PY_W'(cy_i * CELL_DIM + CELL_DIM - 1);
      setup_colour = (colour_q == '0) ? HILITE_COLOUR : colour_q;
      setup_wren   = 1'b0;

      case (cmd_q)
         CMD_UNOUTLINE: setup_colour = GRID_COLOUR;
         CMD_FILL: begin
            setup_mode   = SCAN_INTERIOR;
            setup_last_x = PX_W'((ex_i + 1) * CELL_DIM - 1);
            setup_last_y = PY_W'((ey_i + 1) * CELL_DIM - 1);
            setup_colour = colour_q;
            setup_wren   = 1'b1;
         end
         CMD_CLEAR: begin
            setup_mode   = SCAN_FULL;
            setup_org_x  = '0;
            setup_org_y  = '0;
            setup_last_x = PX_W'(SCREEN_WIDTH - 1);
            setup_last_y = PY_W'(SCREEN_HEIGHT - 1);
            setup_colour = BG_COLOUR;
            setup_wren   = 1'b1;
         end
         default: ;
      endcase
   end

   // The scanner only moves on an accepted pixel, and parks on the last one.
   assign scan_load  = (state == ST_SETUP) && !reject;
   assign scan_stall = !((state == ST_RUN) && iPixReady && !scan_last);

   rect_scanner #(
      .PX_W     (PX_W),
      .PY_W     (PY_W),
      .CELL_DIM (CELL_DIM)
   ) u_scanner (
      .iClk    (iClk),
      .iResetn (iResetn),
      .load    (scan_load),
      .stall   (scan_stall),
      .mode    (setup_mode),
      .org_x   (setup_org_x),
      .org_y   (setup_org_y),
      .last_x  (setup_last_x),
      .last_y  (setup_last_y),
      .x       (oX_pixel),
      .y       (oY_pixel),
      .phase_x (phase_x),
      .phase_y (phase_y),
      .last    (scan_last)
   );

   assign on_grid  = (phase_x == '0) || (phase_x == PH_LAST) ||
                     (phase_y == '0) || (phase_y == PH_LAST);
   assign oColour  = clear_q ? (on_grid ? GRID_COLOUR : BG_COLOUR) : pix_colour_q;
   assign oAddress = A_W'(oY_pixel) * A_W'(SCREEN_WIDTH) + A_W'(oX_pixel);

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         state        <= ST_IDLE;
         oCmdReady    <= 1'b1;
         oBusy        <= 1'b0;
         oDone        <= 1'b0;
         oPlot        <= 1'b0;
         oWren        <= 1'b0;
         cmd_q        <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         colour_q     <= '0;
         brush_q      <= '0;
         pix_colour_q <= '0;
         clear_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (iCmdValid) begin
                  cmd_q     <= iCmd;
                  cx_q      <= iX_cell;
                  cy_q      <= iY_cell;
                  colour_q  <= iColour;
                  brush_q   <= iBrush;
                  oCmdReady <= 1'b0;
                  oBusy     <= 1'b1;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (reject) begin
                  oDone <= 1'b1;
                  oBusy <= 1'b0;
                  state <= ST_FIN;
               end else begin
                  oPlot        <= 1'b1;
                  oWren        <= setup_wren;
                  pix_colour_q <= setup_colour;
                  clear_q      <= (cmd_q == CMD_CLEAR);
                  state        <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (iPixReady && scan_last) begin
                  oPlot <= 1'b0;
                  oWren <= 1'b0;
                  oDone <= 1'b1;
                  oBusy <= 1'b0;
                  state <= ST_FIN;
               end
            end
            ST_FIN: begin
               oDone     <= 1'b0;
               oCmdReady <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
